fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 207 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit for a mixed 16/32-bit instruction stream.
// It reads aligned 32-bit words, splits them into compressed or full
// instructions through a one-halfword parcel buffer, and hands them to
// decode through a single registered output slot with stall back-pressure.
module fetch_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            instr_valid,
    output logic [31:0]     instr_out,
    output logic [XLEN-1:0] instr_pc
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    localparam logic [XLEN-1:0] PC_ZERO  = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] PC_ONE   = XLEN'(1'b1);
    localparam logic [XLEN-1:0] PC_STEP2 = XLEN'(2'd2);
    localparam logic [XLEN-1:0] PC_STEP4 = XLEN'(3'd4);

    // A halfword whose two low bits are not both set is a whole compressed instruction.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [15:0]     buf_q, buf_d;
    logic            buf_v_q, buf_v_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            out_v_q, out_v_d;
    logic [31:0]     out_q, out_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;

    logic            can_load_s;
    logic            buf_c_s;
    logic            issue_s;
    logic [15:0]     lo_s;
    logic [15:0]     hi_s;

    assign can_load_s = !out_v_q || !stall;
    assign buf_c_s    = buf_v_q && is_compressed(buf_q);
    assign lo_s       = imem_rdata[15:0];
    assign hi_s       = imem_rdata[31:16];

    // Next-state logic: redirect handling, parcel assembly and request issue.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        buf_d    = buf_q;
        buf_v_d  = buf_v_q;
        req_d    = req_q;
        addr_d   = addr_q;
        out_v_d  = out_v_q && stall;
        out_d    = out_q;
        out_pc_d = out_pc_q;
        issue_s  = 1'b0;

        case (state_q)
            RUN: begin
                if (redirect) begin
                    out_v_d = 1'b0;
                    buf_v_d = 1'b0;
                    pc_d    = redirect_pc & ~PC_ONE;
                    if (req_q && !imem_ack) begin
                        // The in-flight read must still complete; swallow it in DROP.
                        state_d = DROP;
                    end else begin
                        req_d   = 1'b0;
                        issue_s = 1'b1;
                    end
                end else if (pc_q[1] && buf_c_s) begin
                    // Next instruction is already buffered: emit without memory traffic.
                    if (can_load_s) begin
                        out_v_d  = 1'b1;
                        out_d    = {16'h0000, buf_q};
                        out_pc_d = pc_q;
                        buf_v_d  = 1'b0;
                        pc_d     = pc_q + PC_STEP2;
                        issue_s  = 1'b1;
                    end else begin
                        out_d = out_q;
                    end
                end else if (req_q && imem_ack) begin
                    req_d   = 1'b0;
                    issue_s = 1'b1;
                    if (can_load_s) begin
                        if (!pc_q[1]) begin
                            if (is_compressed(lo_s)) begin
                                out_v_d  = 1'b1;
                                out_d    = {16'h0000, lo_s};
                                out_pc_d = pc_q;
                                buf_d    = hi_s;
                                buf_v_d  = 1'b1;
                                pc_d     = pc_q + PC_STEP2;
                            end else begin
                                out_v_d  = 1'b1;
                                out_d    = imem_rdata;
                                out_pc_d = pc_q;
                                buf_v_d  = 1'b0;
                                pc_d     = pc_q + PC_STEP4;
                            end
                        end else if (buf_v_q) begin
                            // Buffered low half completes with this word's low half.
                            out_v_d  = 1'b1;
                            out_d    = {lo_s, buf_q};
                            out_pc_d = pc_q;
                            buf_d    = hi_s;
                            buf_v_d  = 1'b1;
                            pc_d     = pc_q + PC_STEP4;
                        end else if (is_compressed(hi_s)) begin
                            // Entered at an odd halfword: low half is not ours.
                            out_v_d  = 1'b1;
                            out_d    = {16'h0000, hi_s};
                            out_pc_d = pc_q;
                            buf_v_d  = 1'b0;
                            pc_d     = pc_q + PC_STEP2;
                        end else begin
                            buf_d   = hi_s;
                            buf_v_d = 1'b1;
                        end
                    end else begin
                        // Output slot is held by a stall: drop the word, PC and
                        // buffer stay put so the same address is read again later.
                        buf_v_d = buf_v_q;
                    end
                end else if (!req_q) begin
                    issue_s = 1'b1;
                end else begin
                    issue_s = 1'b0;
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d = redirect_pc & ~PC_ONE;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ack) begin
                    state_d = RUN;
                    req_d   = 1'b0;
                    issue_s = 1'b1;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d = RUN;
                req_d   = 1'b0;
                out_v_d = 1'b0;
                buf_v_d = 1'b0;
            end
        endcase

        if (issue_s) begin
            req_d  = !(pc_d[1] && buf_v_d && is_compressed(buf_d)) && !(out_v_d && stall);
            addr_d = {pc_d[XLEN-1:2], 2'b00} + ((pc_d[1] && buf_v_d) ? PC_STEP4 : PC_ZERO);
        end else begin
            addr_d = addr_q;
        end
    end

    // State, request and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_q     <= RESET_VECTOR;
            buf_q    <= 16'h0000;
            buf_v_q  <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= {RESET_VECTOR[XLEN-1:2], 2'b00};
            out_v_q  <= 1'b0;
            out_q    <= 32'h0000_0000;
            out_pc_q <= PC_ZERO;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            buf_q    <= buf_d;
            buf_v_q  <= buf_v_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            out_v_q  <= out_v_d;
            out_q    <= out_d;
            out_pc_q <= out_pc_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = out_v_q;
    assign instr_out   = out_q;
    assign instr_pc    = out_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table of two-instruction fetch
// scenarios plus hand-written stall, redirect-while-busy and reset sequences.
module tb_fetch_unit;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack    = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall       = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [256];
    int          mem_wait  = 0;
    int          mem_cnt   = 0;
    logic        stray_ack = 1'b0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w0;
        logic [31:0] w1;
        int          wt;
        logic [31:0] i0;
        logic [31:0] p0;
        logic [31:0] i1;
        logic [31:0] p1;
        logic        noreq;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc)
    );

    // Memory model: acks after mem_wait idle cycles of an active request.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_ack = 1'b0;
            mem_cnt  = 0;
        end else if (imem_req) begin
            if (mem_cnt >= mem_wait) begin
                imem_ack   = 1'b1;
                imem_rdata = mem[imem_addr[9:2]];
                mem_cnt    = 0;
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = mem_cnt + 1;
            end
        end else begin
            imem_ack   = stray_ack;
            imem_rdata = 32'hFFFF_FFFF;
            mem_cnt    = 0;
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input string name, input logic [31:0] ei, input logic [31:0] ep);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n = n + 1;
        end while (!instr_valid && n < 60);
        if (!instr_valid) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL %s_timeout actual=no_instr required=instr_valid", name);
        end else begin
            check32({name, "_instr"}, instr_out, ei);
            check32({name, "_pc"}, instr_pc, ep);
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = pc;
        @(negedge clk);
        redirect    = 1'b0;
    endtask

    initial begin
        logic [7:0]  idx;
        logic        found;
        logic [31:0] held_i;
        logic [31:0] held_p;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        mem[0] = 32'h00A0_0093;

        vecs[0] = '{32'h10, 32'h0010_0093, 32'h0000_0013, 0, 32'h0010_0093, 32'h10, 32'h0000_0013, 32'h14, 1'b0};
        vecs[1] = '{32'h20, 32'h4581_4501, 32'h0000_0013, 0, 32'h0000_4501, 32'h20, 32'h0000_4581, 32'h22, 1'b1};
        vecs[2] = '{32'h30, 32'h0093_4501, 32'h0001_00A0, 2, 32'h0000_4501, 32'h30, 32'h00A0_0093, 32'h32, 1'b0};
        vecs[3] = '{32'h42, 32'h4505_1234, 32'h0000_0013, 0, 32'h0000_4505, 32'h42, 32'h0000_0013, 32'h44, 1'b0};
        vecs[4] = '{32'h52, 32'h0093_FFFF, 32'h0001_00A0, 1, 32'h00A0_0093, 32'h52, 32'h0000_0001, 32'h56, 1'b0};
        vecs[5] = '{32'h60, 32'h00B0_0113, 32'h0100_0193, 3, 32'h00B0_0113, 32'h60, 32'h0100_0193, 32'h64, 1'b0};
        vecs[6] = '{32'hFFFF_FFFC, 32'h0050_0093, 32'h0070_0093, 0, 32'h0050_0093, 32'hFFFF_FFFC, 32'h0070_0093, 32'h0, 1'b0};

        // Reset state and first fetch out of reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_req",   {31'b0, imem_req},    32'h0);
        check32("rst_valid", {31'b0, instr_valid}, 32'h0);
        check32("rst_instr", instr_out,            32'h0);
        check32("rst_pc",    instr_pc,             32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check32("boot_req",   {31'b0, imem_req},    32'h1);
        check32("boot_addr",  imem_addr,            32'h0);
        check32("boot_novld", {31'b0, instr_valid}, 32'h0);
        @(negedge clk);
        check32("boot_valid", {31'b0, instr_valid}, 32'h1);
        check32("boot_instr", instr_out,            32'h00A0_0093);
        check32("boot_pc",    instr_pc,             32'h0);

        // Vector table: redirect to pc, expect two consecutive instructions.
        for (int v = 0; v < 7; v++) begin
            mem_wait = vecs[v].wt;
            idx      = vecs[v].pc[9:2];
            mem[idx] = vecs[v].w0;
            idx      = idx + 8'd1;
            mem[idx] = vecs[v].w1;
            do_redirect(vecs[v].pc);
            expect_instr($sformatf("v%0d_a", v), vecs[v].i0, vecs[v].p0);
            if (vecs[v].noreq) check32($sformatf("v%0d_noreq", v), {31'b0, imem_req}, 32'h0);
            expect_instr($sformatf("v%0d_b", v), vecs[v].i1, vecs[v].p1);
        end

        // Stall held three cycles, then redirect under stall.
        mem_wait = 0;
        mem[40]  = 32'h0010_0113;
        mem[41]  = 32'h0020_0113;
        mem[42]  = 32'h0030_0113;
        do_redirect(32'hA0);
        expect_instr("stl_first", 32'h0010_0113, 32'hA0);
        held_i = instr_out;
        held_p = instr_pc;
        stall  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check32($sformatf("stl_valid%0d", k), {31'b0, instr_valid}, 32'h1);
            check32($sformatf("stl_instr%0d", k), instr_out, held_i);
            check32($sformatf("stl_pc%0d", k),    instr_pc,  held_p);
            check32($sformatf("stl_noreq%0d", k), {31'b0, imem_req}, 32'h0);
        end
        stall = 1'b0;
        expect_instr("stl_next", 32'h0020_0113, 32'hA4);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hA8;
        @(negedge clk);
        redirect = 1'b0;
        stall    = 1'b0;
        check32("redir_flush", {31'b0, instr_valid}, 32'h0);
        expect_instr("redir_tgt", 32'h0030_0113, 32'hA8);

        // Redirect while a two-wait request to 0x8 is outstanding.
        mem_wait = 2;
        mem[2]   = 32'h1234_5678;
        mem[64]  = 32'h4505_0093;
        do_redirect(32'h8);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
            else @(negedge clk);
        end
        check32("drop_seen8", {31'b0, found}, 32'h1);
        redirect    = 1'b1;
        redirect_pc = 32'h102;
        @(negedge clk);
        redirect = 1'b0;
        check32("drop_req",   {31'b0, imem_req},    32'h1);
        check32("drop_addr",  imem_addr,            32'h8);
        check32("drop_novld", {31'b0, instr_valid}, 32'h0);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            @(negedge clk);
            if (imem_req && imem_addr != 32'h8) found = 1'b1;
        end
        check32("drop_newreq",  {31'b0, found}, 32'h1);
        check32("drop_newaddr", imem_addr,      32'h100);
        expect_instr("drop_instr", 32'h0000_4505, 32'h102);

        // Reset asserted during an outstanding request.
        mem_wait = 5;
        mem[0]   = 32'h00C0_0093;
        do_redirect(32'h80);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (imem_req) found = 1'b1;
            else @(negedge clk);
        end
        check32("mrst_busy", {31'b0, found}, 32'h1);
        rst_n = 1'b0;
        #1;
        check32("mrst_req",   {31'b0, imem_req},    32'h0);
        check32("mrst_valid", {31'b0, instr_valid}, 32'h0);
        check32("mrst_instr", instr_out,            32'h0);
        check32("mrst_pc",    instr_pc,             32'h0);
        @(posedge clk);
        #1 rst_n  = 1'b1;
        stray_ack = 1'b1;
        @(posedge clk);
        stray_ack = 1'b0;
        #1;
        check32("mrst_req1",  {31'b0, imem_req}, 32'h1);
        check32("mrst_addr1", imem_addr,         32'h0);
        expect_instr("mrst_first", 32'h00C0_0093, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
